rv32_mem_arbiter: RTL and testbench
===================================

// Module: rv32_mem_arbiter
// PURPOSE
//  Shares one memory port between the core's instruction-fetch and load/store (data) requesters.
//  One transaction is outstanding at a time.
//  Data requests have fixed priority; a streak limit prevents fetch starvation.
//  A timeout aborts hung bus cycles and flags an error.
//  Sits between rv32 core fetch/LSU and the unified instruction/data memory.
// PARAMETERS
//  AW           32  address width
//  DW           32  data width (strobe width DW/8)
//  MAX_D_STREAK 4   consecutive data grants allowed while fetch waits (>=1)
//  TIMEOUT      255 BUSY cycles without mem_ready before abort (>=1); counter width $clog2(TIMEOUT+1)
// PORTS
//  clk        in   1     clock, rising edge
//  reset      in   1     async reset, active high
//  if_req     in   1     fetch request; hold with if_addr stable until if_gnt
//  if_addr    in   AW    fetch address
//  if_gnt     out  1     fetch accepted this cycle (combinational, IDLE only)
//  if_rvalid  out  1     fetch complete, 1-cycle pulse
//  if_rdata   out  DW    fetch data, valid with if_rvalid
//  if_err     out  1     fetch timed out, valid with if_rvalid
//  d_req      in   1     data request; hold with d_we/d_addr/d_wdata/d_wstrb stable until d_gnt
//  d_we       in   1     1 = write, 0 = read
//  d_addr     in   AW    data address
//  d_wdata    in   DW    write data
//  d_wstrb    in   DW/8  byte strobes (ignored on reads)
//  d_gnt      out  1     data accepted this cycle (combinational, IDLE only)
//  d_rvalid   out  1     data complete (read data or write ack), 1-cycle pulse
//  d_rdata    out  DW    read data; 0 on write ack and on error
//  d_err      out  1     data timed out, valid with d_rvalid
//  mem_req    out  1     bus request, registered; held until mem_ready
//  mem_we     out  1     bus write
//  mem_addr   out  AW    bus address (latched)
//  mem_wdata  out  DW    bus write data (latched; 0 for fetch)
//  mem_wstrb  out  DW/8  bus strobes (0 for fetch and reads)
//  mem_ready  in   1     bus completes the cycle when sampled high with mem_req=1
//  mem_rdata  in   DW    bus read data, valid with mem_ready
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; streak, timeout and latches cleared.
//   Reset mid-transaction drops mem_req immediately; no rvalid is issued.
//  FSM states: IDLE, BUSY_IF, BUSY_D.
//  IDLE arbitration, evaluated combinationally each cycle:
//   - d_req only: d_gnt=1.
//   - if_req only: if_gnt=1.
//   - both: d_gnt, unless streak==MAX_D_STREAK, then if_gnt.
//   - never both grants in one cycle; no grant outside IDLE.
//  On a grant edge:
//   - latch the owner's signals into mem_*; mem_req=1 from the next cycle.
//   - go to BUSY_IF or BUSY_D; clear the timeout counter.
//  Streak counter:
//   - +1 on a d_gnt while if_req=1, saturating at MAX_D_STREAK.
//   - cleared on if_gnt, and on a d_gnt while if_req=0.
//  BUSY with mem_ready=1:
//   - next cycle: mem_req=0, state=IDLE, owner rvalid=1.
//   - owner rdata = captured mem_rdata (reads only), err=0.
//  BUSY with mem_ready=0:
//   - timeout counter +1.
//   - when the counter reaches TIMEOUT (TIMEOUT consecutive BUSY cycles without mem_ready),
//     the next cycle gives mem_req=0, IDLE, owner rvalid=1, err=1, rdata=0.
//  Throughput: a new grant may occur in the same cycle as the previous rvalid.
//   - min latency: grant cycle t, mem_req at t+1, mem_ready at t+1, rvalid at t+2.
//   - back-to-back max: 1 transaction per 2 cycles.
//  Requester deasserting req before its grant: legal; nothing issued.
//   - a req withdrawn in IDLE is simply not granted.
//  rdata/err hold their last values between pulses; rvalid is the only qualifier.
// TESTING
//  1. Single fetch, if_addr=0x100, mem_ready at first mem_req cycle, rdata=0x00500093
//     -> if_gnt@t, mem_req@t+1, if_rvalid@t+2, if_rdata=0x00500093.
//  2. Simultaneous if_req+d_req (read 0x2000)
//     -> d_gnt first; IF granted in the IDLE cycle after d_rvalid.
//  3. d_req held continuously with if_req=1, MAX_D_STREAK=4
//     -> 4 data grants, then 1 fetch grant, then the streak restarts.
//  4. Write d_addr=0x3004, d_wdata=0xDEADBEEF, d_wstrb=4'b0011, mem_ready after 3 cycles
//     -> mem_* held 3 cycles; d_rvalid=1, d_rdata=0, d_err=0.
//  5. mem_ready never asserted, TIMEOUT=8 -> mem_req high 8 cycles, then d_rvalid=1 and d_err=1.
//  6. reset pulse while BUSY_D -> mem_req=0 asynchronously; no rvalid; next request arbitrates from IDLE.

Source files
------------

// File: rtl/rv32_mem_arbiter_if.sv
// Bus bundle between the core's fetch/LSU requesters, the arbiter and the
// unified memory port. The arbiter takes the slave view; the environment
// (core + memory model) takes the master view.
interface rv32_mem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  // instruction fetch requester
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_gnt;
  logic            if_rvalid;
  logic [DW-1:0]   if_rdata;
  logic            if_err;
  // load/store requester
  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_wstrb;
  logic            d_gnt;
  logic            d_rvalid;
  logic [DW-1:0]   d_rdata;
  logic            d_err;
  // shared memory port
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wstrb;
  logic            mem_ready;
  logic [DW-1:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  mem_ready, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, if_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    output mem_ready, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/rv32_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// One transaction outstanding; data has priority, bounded by a streak limit
// so fetch cannot starve; a timeout aborts hung bus cycles with an error.
module rv32_mem_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input logic                clk,
  input logic                reset,
  rv32_mem_arbiter_if.slave  bus
);

  localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY_IF,
    S_BUSY_D
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SW-1:0]    r_streak;
  logic [CW-1:0]    r_tmo;

  logic             r_mem_req;
  logic             r_mem_we;
  logic [AW-1:0]    r_mem_addr;
  logic [DW-1:0]    r_mem_wdata;
  logic [DW/8-1:0]  r_mem_wstrb;

  logic             r_if_rvalid;
  logic [DW-1:0]    r_if_rdata;
  logic             r_if_err;
  logic             r_d_rvalid;
  logic [DW-1:0]    r_d_rdata;
  logic             r_d_err;

  logic             w_if_gnt;
  logic             w_d_gnt;
  logic             w_busy;
  logic             w_ready;
  logic             w_abort;
  logic             w_fin;
  logic             w_streak_max;

  // State register; reset returns to IDLE from any state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Arbitration, completion/timeout detection and next state.
  always_comb begin
    w_if_gnt     = 1'b0;
    w_d_gnt      = 1'b0;
    w_state_nxt  = r_state;
    w_streak_max = (r_streak == SW'(MAX_D_STREAK));
    w_busy       = (r_state != S_IDLE);
    w_ready      = w_busy && bus.mem_ready;
    // abort on the edge that ends the TIMEOUT-th busy cycle without ready
    w_abort      = w_busy && !bus.mem_ready && (r_tmo == CW'(TIMEOUT - 1));
    w_fin        = w_ready || w_abort;
    case (r_state)
      S_IDLE: begin
        if (bus.d_req && !(bus.if_req && w_streak_max)) begin
          w_d_gnt     = 1'b1;
          w_state_nxt = S_BUSY_D;
        end else if (bus.if_req) begin
          w_if_gnt    = 1'b1;
          w_state_nxt = S_BUSY_IF;
        end
      end
      S_BUSY_IF, S_BUSY_D: begin
        if (w_fin) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Consecutive data-grant count while fetch is waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_streak <= '0;
    end else if (w_if_gnt) begin
      r_streak <= '0;
    end else if (w_d_gnt) begin
      if (!bus.if_req)       r_streak <= '0;
      else if (!w_streak_max) r_streak <= r_streak + SW'(1);
    end
  end

  // Bus cycle launch, timeout counting and response capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_if_err    <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_d_rdata   <= '0;
      r_d_err     <= 1'b0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      if (w_d_gnt) begin
        r_tmo       <= '0;
        r_mem_req   <= 1'b1;
        r_mem_we    <= bus.d_we;
        r_mem_addr  <= bus.d_addr;
        r_mem_wdata <= bus.d_wdata;
        r_mem_wstrb <= bus.d_we ? bus.d_wstrb : '0;
      end else if (w_if_gnt) begin
        r_tmo       <= '0;
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= bus.if_addr;
        r_mem_wdata <= '0;
        r_mem_wstrb <= '0;
      end else if (w_fin) begin
        r_mem_req <= 1'b0;
        if (r_state == S_BUSY_IF) begin
          r_if_rvalid <= 1'b1;
          r_if_err    <= w_abort;
          r_if_rdata  <= w_abort ? '0 : bus.mem_rdata;
        end else begin
          r_d_rvalid  <= 1'b1;
          r_d_err     <= w_abort;
          r_d_rdata   <= (w_abort || r_mem_we) ? '0 : bus.mem_rdata;
        end
      end else if (w_busy) begin
        r_tmo <= r_tmo + CW'(1);
      end
    end
  end

  assign bus.if_gnt    = w_if_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wstrb = r_mem_wstrb;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_err    = r_if_err;
  assign bus.d_rvalid  = r_d_rvalid;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_err     = r_d_err;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Directed bench for rv32_mem_arbiter (MAX_D_STREAK=4, TIMEOUT=8).
module tb_rv32_mem_arbiter;

  localparam int unsigned TMO = 8;

  logic clk;
  logic reset;

  rv32_mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  rv32_mem_arbiter #(
    .AW(32), .DW(32), .MAX_D_STREAK(4), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    string       name;
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          delay;       // busy cycles with ready low before ready
    logic        never;       // ready never comes -> timeout
    logic [31:0] mrdata;      // value on mem_rdata when ready is given
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_mwe;
    logic [31:0] exp_mwdata;
    logic [3:0]  exp_mwstrb;
    int          exp_high;    // cycles mem_req stays high
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input vec_t t);
    int  c;
    int  n_high;
    bit  done;
    logic rv;
    if (t.is_d) begin
      bus.d_req   = 1'b1;
      bus.d_we    = t.we;
      bus.d_addr  = t.addr;
      bus.d_wdata = t.wdata;
      bus.d_wstrb = t.wstrb;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = t.addr;
    end
    #1;
    chk({t.name, " gnt"},       t.is_d ? bus.d_gnt : bus.if_gnt, 1);
    chk({t.name, " other gnt"}, t.is_d ? bus.if_gnt : bus.d_gnt, 0);
    step();
    bus.d_req  = 1'b0;
    bus.if_req = 1'b0;
    chk({t.name, " mem_addr"},  bus.mem_addr, t.addr);
    chk({t.name, " mem_we"},    bus.mem_we, t.exp_mwe);
    chk({t.name, " mem_wdata"}, bus.mem_wdata, t.exp_mwdata);
    chk({t.name, " mem_wstrb"}, bus.mem_wstrb, t.exp_mwstrb);
    c = 0; n_high = 0; done = 0;
    while (!done && c < 40) begin
      rv = t.is_d ? bus.d_rvalid : bus.if_rvalid;
      if (rv) begin
        done = 1;
      end else begin
        if (bus.mem_req) n_high++;
        bus.mem_ready = !t.never && (c == t.delay);
        bus.mem_rdata = bus.mem_ready ? t.mrdata : 32'hBAD0BAD0;
        step();
        bus.mem_ready = 1'b0;
        c++;
      end
    end
    chk({t.name, " rvalid seen"},  32'(done), 1);
    chk({t.name, " mem_req cyc"},  n_high, t.exp_high);
    chk({t.name, " mem_req low"},  bus.mem_req, 0);
    chk({t.name, " rdata"},        t.is_d ? bus.d_rdata : bus.if_rdata, t.exp_rdata);
    chk({t.name, " err"},          t.is_d ? bus.d_err : bus.if_err, t.exp_err);
    chk({t.name, " other rvalid"}, t.is_d ? bus.if_rvalid : bus.d_rvalid, 0);
    step();
    chk({t.name, " rvalid pulse"}, t.is_d ? bus.d_rvalid : bus.if_rvalid, 0);
    chk({t.name, " rdata hold"},   t.is_d ? bus.d_rdata : bus.if_rdata, t.exp_rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //            name      d  we addr          wdata         strb   dly nev mrdata        exp_rdata     err mwe mwdata        mstrb  high
    vecs[0] = '{"fetch",    0, 0, 32'h00000100, 32'h0,        4'h0,  0, 0, 32'h00500093, 32'h00500093, 0, 0, 32'h0,        4'h0,  1};
    vecs[1] = '{"rd",       1, 0, 32'h00002000, 32'h0,        4'hF,  1, 0, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0, 32'h0,        4'h0,  2};
    vecs[2] = '{"wr",       1, 1, 32'h00003004, 32'hDEADBEEF, 4'h3,  2, 0, 32'h12345678, 32'h0,        0, 1, 32'hDEADBEEF, 4'h3,  3};
    vecs[3] = '{"rd_tmo",   1, 0, 32'h00004000, 32'h0,        4'h0,  0, 1, 32'h0,        32'h0,        1, 0, 32'h0,        4'h0,  TMO};
    vecs[4] = '{"fetch_d3", 0, 0, 32'h00000104, 32'h0,        4'h0,  3, 0, 32'h00A00113, 32'h00A00113, 0, 0, 32'h0,        4'h0,  4};
    vecs[5] = '{"if_tmo",   0, 0, 32'h00000108, 32'h0,        4'h0,  0, 1, 32'h0,        32'h0,        1, 0, 32'h0,        4'h0,  TMO};
    vecs[6] = '{"wr_full",  1, 1, 32'h00005000, 32'hA5A5A5A5, 4'hF,  0, 0, 32'h55555555, 32'h0,        0, 1, 32'hA5A5A5A5, 4'hF,  1};

    bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
    bus.mem_ready = 0; bus.mem_rdata = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst mem_req",   bus.mem_req, 0);
    chk("rst mem_addr",  bus.mem_addr, 0);
    chk("rst if_rvalid", bus.if_rvalid, 0);
    chk("rst d_rvalid",  bus.d_rvalid, 0);
    chk("rst d_err",     bus.d_err, 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // simultaneous requests: data first, fetch granted in the rvalid cycle
    bus.if_req = 1; bus.if_addr = 32'h100;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h2000; bus.d_wstrb = '0; bus.d_wdata = '0;
    #1;
    chk("sim d_gnt",  bus.d_gnt, 1);
    chk("sim if_gnt", bus.if_gnt, 0);
    step();
    bus.d_req = 0;
    #1;
    chk("sim busy if_gnt", bus.if_gnt, 0);
    chk("sim mem_addr d",  bus.mem_addr, 32'h2000);
    bus.mem_ready = 1; bus.mem_rdata = 32'h00000077;
    step();
    bus.mem_ready = 0;
    #1;
    chk("sim d_rvalid",     bus.d_rvalid, 1);
    chk("sim d_rdata",      bus.d_rdata, 32'h77);
    chk("sim if_gnt after", bus.if_gnt, 1);
    step();
    bus.if_req = 0;
    chk("sim mem_addr if", bus.mem_addr, 32'h100);
    chk("sim mem_req if",  bus.mem_req, 1);
    bus.mem_ready = 1; bus.mem_rdata = 32'h00500093;
    step();
    bus.mem_ready = 0;
    chk("sim if_rvalid", bus.if_rvalid, 1);
    chk("sim if_rdata",  bus.if_rdata, 32'h00500093);
    step();

    // streak: D,D,D,D then F, then data wins again
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h6000;
    bus.if_req = 1; bus.if_addr = 32'h200;
    for (int g = 0; g < 6; g++) begin
      #1;
      chk($sformatf("streak%0d if_gnt", g), bus.if_gnt, (g == 4) ? 1 : 0);
      chk($sformatf("streak%0d d_gnt", g),  bus.d_gnt,  (g == 4) ? 0 : 1);
      step();
      bus.mem_ready = 1; bus.mem_rdata = 32'(g);
      step();
      bus.mem_ready = 0;
    end
    bus.d_req = 0; bus.if_req = 0;
    step();
    step();

    // reset while BUSY_D: mem_req drops at once, no rvalid follows
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h7000; bus.d_wdata = 32'h1; bus.d_wstrb = 4'hF;
    #1;
    chk("rstbusy d_gnt", bus.d_gnt, 1);
    step();
    bus.d_req = 0;
    chk("rstbusy mem_req", bus.mem_req, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rstbusy async mem_req",  bus.mem_req, 0);
    chk("rstbusy async mem_addr", bus.mem_addr, 0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rstbusy no rvalid", bus.d_rvalid, 0);
      step();
    end
    run_txn(vecs[1]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
